// File: rtl/alarm_ctrl.sv
// alarm_ctrl
// Alarm controller that sits after the 24-hour time-of-day counter. It holds
// a programmable alarm time and compares it with the running time on every
// clk_1hz tick. A small state machine drives the buzzer enable and handles
// dismiss, auto-timeout and, optionally, snooze.
//
// Parameters:
//   SNOOZE_MIN     snooze length in minutes (1..59)
//   RING_TIMEOUT_S maximum ringing duration in seconds (1..3599)
//
// Ports:
//   clk_1hz        in   1 Hz tick clock, shared with the time counter
//   reset          in   asynchronous, active-high
//   seconds        in   current seconds 0..59
//   minutes        in   current minutes 0..59
//   hours          in   current hours 0..23
//   set_alarm      in   load set_hours/set_minutes into the alarm registers
//   set_hours      in   new alarm hour
//   set_minutes    in   new alarm minute
//   alarm_en       in   alarm armed (level)
//   snooze         in   snooze request (level)
//   dismiss        in   dismiss request (level)
//   ringing        out  buzzer enable
//   snoozed        out  high while snoozing
//   alarm_hours    out  stored alarm hour
//   alarm_minutes  out  stored alarm minute
//
// Build option:
//   ALARM_SNOOZE_EN  when defined, the SNOOZE state and its counter exist.
//                    When undefined, snooze is ignored and snoozed is 0.
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk_1hz,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_alarm,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ringing,
  output logic       snoozed,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef ALARM_SNOOZE_EN
    RINGING = 2'd1,
    SNOOZE  = 2'd2
`else
    RINGING = 2'd1
`endif
  } state_t;

  localparam logic [11:0] RING_LAST = 12'(RING_TIMEOUT_S - 1);

  state_t      state;
  state_t      state_n;
  logic [11:0] ring_cnt;
  logic [11:0] ring_cnt_n;
  logic        match;

`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60 - 1);

  logic [11:0] snz_cnt;
  logic [11:0] snz_cnt_n;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Alarm time registers. Out-of-range requests are dropped so the stored
  // time is always a legal clock value.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      alarm_hours   <= 5'd7;
      alarm_minutes <= 6'd0;
    end else if (set_alarm && (set_hours <= 5'd23) && (set_minutes <= 6'd59)) begin
      alarm_hours   <= set_hours;
      alarm_minutes <= set_minutes;
    end
  end

  // Seconds must be zero so the alarm fires only once per matching minute.
  assign match = (hours == alarm_hours) && (minutes == alarm_minutes) &&
                 (seconds == 6'd0);

  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= 12'd0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= 12'd0;
`endif
    end else begin
      state    <= state_n;
      ring_cnt <= ring_cnt_n;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= snz_cnt_n;
`endif
    end
  end

  // Next-state logic. Disarming overrides everything; inside RINGING the
  // order is dismiss, then snooze, then timeout. Terminal compares come
  // before the counter updates so neither counter ever wraps.
  always_comb begin
    state_n    = state;
    ring_cnt_n = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_n  = snz_cnt;
`endif
    if (!alarm_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state_n    = RINGING;
            ring_cnt_n = 12'd0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_n   = SNOOZE;
            snz_cnt_n = SNZ_LOAD;
`endif
          end else if (ring_cnt == RING_LAST) begin
            state_n = IDLE;
          end else begin
            ring_cnt_n = ring_cnt + 12'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss) begin
            state_n = IDLE;
          end else if (snz_cnt == 12'd0) begin
            state_n    = RINGING;
            ring_cnt_n = 12'd0;
          end else begin
            snz_cnt_n = snz_cnt - 12'd1;
          end
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from the state register, so they are glitch-free
  // and clear asynchronously with reset.
  assign ringing = (state == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snoozed = (state == SNOOZE);
`else
  assign snoozed = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl
// Directed self-checking bench for alarm_ctrl with default parameters
// (9 minute snooze, 60 second ring timeout). The bench plays the role of the
// time-of-day counter: after each clk_1hz edge it advances hours/minutes/
// seconds by one second. Snooze scenarios are exercised when ALARM_SNOOZE_EN
// is defined; otherwise the bench checks that snooze has no effect.
module tb_alarm_ctrl;

  logic       clk_1hz;
  logic       reset;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       set_alarm;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic       ringing;
  logic       snoozed;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;

  int checks;
  int failures;
  int cnt;
  int cnt2;

  alarm_ctrl dut (
    .clk_1hz      (clk_1hz),
    .reset        (reset),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .set_alarm    (set_alarm),
    .set_hours    (set_hours),
    .set_minutes  (set_minutes),
    .alarm_en     (alarm_en),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes)
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  // Advance n clock edges; after each edge (plus 1 time unit) the emulated
  // time counter moves forward one second.
  task applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1hz);
      #1;
      if (seconds == 6'd59) begin
        seconds = 6'd0;
        if (minutes == 6'd59) begin
          minutes = 6'd0;
          hours   = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes = minutes + 6'd1;
        end
      end else begin
        seconds = seconds + 6'd1;
      end
    end
  endtask

  task checkOutput(input string tag, input logic [11:0] observed,
                   input logic [11:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task setTime(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hours   = h;
    minutes = m;
    seconds = s;
  endtask

  // Alarm is 23:59 when this is used: the counter shows 23:59:00 after the
  // first edge and ringing rises on the second.
  task triggerAlarm();
    setTime(5'd23, 6'd58, 6'd59);
    applyStimulus(2);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    set_alarm   = 1'b0;
    set_hours   = 5'd0;
    set_minutes = 6'd0;
    alarm_en    = 1'b0;
    snooze      = 1'b0;
    dismiss     = 1'b0;
    setTime(5'd0, 6'd0, 6'd0);
    #1;
    checkOutput("rst_ringing", 12'(ringing), 12'd0);
    checkOutput("rst_snoozed", 12'(snoozed), 12'd0);
    checkOutput("rst_alarm_h", 12'(alarm_hours), 12'd7);
    checkOutput("rst_alarm_m", 12'(alarm_minutes), 12'd0);
    @(posedge clk_1hz);
    @(posedge clk_1hz);
    #1;
    reset = 1'b0;

    // Trigger latency around 07:00:00.
    alarm_en = 1'b1;
    setTime(5'd6, 6'd59, 6'd58);
    applyStimulus(1);
    checkOutput("pre_trig_0659_59", 12'(ringing), 12'd0);
    applyStimulus(1);
    checkOutput("pre_trig_0700_00", 12'(ringing), 12'd0);
    applyStimulus(1);
    checkOutput("trig_0700_01", 12'(ringing), 12'd1);

    // Unattended ring lasts the full timeout and does not retrigger at 07:01.
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!ringing) break;
      cnt++;
      applyStimulus(1);
    end
    checkOutput("ring_duration", 12'(cnt), 12'd60);
    checkOutput("ring_ended", 12'(ringing), 12'd0);
    applyStimulus(3);
    checkOutput("no_retrigger", 12'(ringing), 12'd0);

    // Out-of-range alarm loads are dropped.
    set_alarm = 1'b1; set_hours = 5'd24; set_minutes = 6'd10;
    applyStimulus(1);
    set_alarm = 1'b0;
    checkOutput("bad_hour_h", 12'(alarm_hours), 12'd7);
    checkOutput("bad_hour_m", 12'(alarm_minutes), 12'd0);
    set_alarm = 1'b1; set_hours = 5'd5; set_minutes = 6'd60;
    applyStimulus(1);
    set_alarm = 1'b0;
    checkOutput("bad_min_h", 12'(alarm_hours), 12'd7);
    checkOutput("bad_min_m", 12'(alarm_minutes), 12'd0);
    set_alarm = 1'b1; set_hours = 5'd23; set_minutes = 6'd59;
    applyStimulus(1);
    set_alarm = 1'b0;
    checkOutput("set_2359_h", 12'(alarm_hours), 12'd23);
    checkOutput("set_2359_m", 12'(alarm_minutes), 12'd59);

    // Ring at 23:59, then dismiss and snooze on the same edge.
    setTime(5'd23, 6'd58, 6'd59);
    applyStimulus(1);
    checkOutput("late_pre_trig", 12'(ringing), 12'd0);
    applyStimulus(1);
    checkOutput("late_trig", 12'(ringing), 12'd1);
    dismiss = 1'b1; snooze = 1'b1;
    applyStimulus(1);
    dismiss = 1'b0; snooze = 1'b0;
    checkOutput("dis_snz_ringing", 12'(ringing), 12'd0);
    checkOutput("dis_snz_snoozed", 12'(snoozed), 12'd0);

`ifdef ALARM_SNOOZE_EN
    // Snooze on the third ringing cycle, then dismiss the second ring.
    triggerAlarm();
    checkOutput("snz_trig", 12'(ringing), 12'd1);
    applyStimulus(2);
    snooze = 1'b1;
    applyStimulus(1);
    snooze = 1'b0;
    checkOutput("snz_taken_snoozed", 12'(snoozed), 12'd1);
    checkOutput("snz_taken_ringing", 12'(ringing), 12'd0);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!snoozed) break;
      cnt++;
      applyStimulus(1);
    end
    checkOutput("snz_duration", 12'(cnt), 12'd540);
    checkOutput("snz_rering", 12'(ringing), 12'd1);
    applyStimulus(2);
    dismiss = 1'b1;
    applyStimulus(1);
    dismiss = 1'b0;
    checkOutput("dis2_ringing", 12'(ringing), 12'd0);
    checkOutput("dis2_snoozed", 12'(snoozed), 12'd0);

    // Snooze on the last ringing cycle beats the timeout; then disarm.
    triggerAlarm();
    applyStimulus(59);
    checkOutput("ring_last_cycle", 12'(ringing), 12'd1);
    snooze = 1'b1;
    applyStimulus(1);
    snooze = 1'b0;
    checkOutput("timeout_vs_snooze", 12'(snoozed), 12'd1);
    applyStimulus(5);
    alarm_en = 1'b0;
    applyStimulus(1);
    checkOutput("disarm_snoozed", 12'(snoozed), 12'd0);
    checkOutput("disarm_ringing", 12'(ringing), 12'd0);
    alarm_en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1);
      if (ringing) cnt++;
    end
    checkOutput("no_ring_after_disarm", 12'(cnt), 12'd0);
`else
    // Without the snooze feature, holding snooze changes nothing.
    triggerAlarm();
    snooze = 1'b1;
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!ringing) break;
      cnt++;
      if (snoozed) cnt2++;
      applyStimulus(1);
    end
    snooze = 1'b0;
    checkOutput("nosnz_ring_duration", 12'(cnt), 12'd60);
    checkOutput("nosnz_snoozed_seen", 12'(cnt2), 12'd0);
    checkOutput("nosnz_snoozed_after", 12'(snoozed), 12'd0);
    triggerAlarm();
    applyStimulus(5);
    alarm_en = 1'b0;
    applyStimulus(1);
    checkOutput("disarm_ringing", 12'(ringing), 12'd0);
    alarm_en = 1'b1;
`endif

    // Asynchronous reset in the middle of a ring.
    triggerAlarm();
    applyStimulus(3);
    checkOutput("pre_async_ringing", 12'(ringing), 12'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_ringing", 12'(ringing), 12'd0);
    checkOutput("async_rst_alarm_h", 12'(alarm_hours), 12'd7);
    checkOutput("async_rst_alarm_m", 12'(alarm_minutes), 12'd0);
    applyStimulus(1);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
